// File: rtl/char_stream_cipher.sv
// Modular add/subtract stream cipher over 8-bit chars. The key is latched from the
// key generator once per message, then each accepted char is transformed with 1-cycle latency.

module char_xform #(
  parameter int P_MOD = 227
) (
  input  logic       dec,
  input  logic [7:0] key,
  input  logic [7:0] ch,
  output logic [7:0] res,
  output logic       invalid
);
  localparam logic [8:0] PM = 9'(P_MOD);

  logic [8:0] sum, wrap;

  always_comb begin
    sum     = {1'b0, ch} + {1'b0, key};
    wrap    = {1'b0, ch} + PM - {1'b0, key};
    invalid = ({1'b0, ch} >= PM);
    res     = 8'h00;
    if (!invalid) begin
      if (dec) res = (ch >= key) ? (ch - key) : wrap[7:0];
      else     res = (sum >= PM) ? 8'(sum - PM) : sum[7:0];
    end
  end
endmodule

module char_stream_cipher #(
  parameter int P_MOD   = 227,
  parameter int MAX_LEN = 32,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] pk_in,
  input  logic       pk_ready,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_char,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       err_invalid_char,
  output logic       err_overlength,
  output logic       err_mode
);
  typedef enum logic [1:0] {IDLE, WAIT_KEY, RUN, FLUSH} state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] ch;
  } resp_t;

  state_t     state, state_nxt;
  logic       dec_r;
  logic [7:0] key_r;
  logic [CNT_W-1:0] cnt_r, cnt_inc;
  resp_t      resp_r;
  logic       out_valid_r, done_r, err_inv_r, err_ovl_r, err_mode_r;

  logic       start_ok, start_bad, accept, out_hs, is_null, hit_max, last_char;
  logic [7:0] xf_char;
  logic       xf_invalid;

  char_xform #(.P_MOD(P_MOD)) u_xform (
    .dec     (dec_r),
    .key     (key_r),
    .ch      (in_char),
    .res     (xf_char),
    .invalid (xf_invalid)
  );

  assign start_ok  = (state == IDLE) && start && !mode[1];
  assign start_bad = (state == IDLE) && start && mode[1];
  assign in_ready  = (state == RUN) && (!out_valid_r || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid_r && out_ready;
  assign is_null   = (in_char == 8'h00);
  assign cnt_inc   = cnt_r + CNT_W'(1);
  assign hit_max   = (cnt_inc == CNT_W'(MAX_LEN));
  assign last_char = is_null || hit_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_ok)            state_nxt = WAIT_KEY;
      WAIT_KEY: if (pk_ready)            state_nxt = RUN;
      RUN:      if (accept && last_char) state_nxt = FLUSH;
      FLUSH:    if (out_hs)              state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_r       <= 1'b0;
      key_r       <= 8'h00;
      cnt_r       <= '0;
      resp_r      <= '0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      err_inv_r   <= 1'b0;
      err_ovl_r   <= 1'b0;
      err_mode_r  <= 1'b0;
    end else begin
      done_r     <= (state == FLUSH) && out_hs;
      err_mode_r <= start_bad;
      if (start_ok) begin
        dec_r     <= mode[0];
        cnt_r     <= '0;
        err_inv_r <= 1'b0;
        err_ovl_r <= 1'b0;
      end
      if (state == WAIT_KEY && pk_ready) key_r <= pk_in;
      // A new accept refills the output register in the same cycle it drains.
      if (accept) begin
        cnt_r       <= cnt_inc;
        out_valid_r <= 1'b1;
        resp_r.ch   <= is_null ? 8'h00 : xf_char;
        resp_r.last <= last_char;
        if (xf_invalid)           err_inv_r <= 1'b1;
        if (hit_max && !is_null)  err_ovl_r <= 1'b1;
      end else if (out_hs) begin
        out_valid_r <= 1'b0;
        resp_r.last <= 1'b0;
      end
    end
  end

  assign out_valid        = out_valid_r;
  assign out_char         = resp_r.ch;
  assign out_last         = resp_r.last;
  assign busy             = (state != IDLE);
  assign done             = done_r;
  assign err_invalid_char = err_inv_r;
  assign err_overlength   = err_ovl_r;
  assign err_mode         = err_mode_r;
endmodule

// File: tb/tb_char_stream_cipher.sv
// Scoreboard bench for char_stream_cipher: expected chars are queued on accept and
// compared by a monitor whenever an output handshake is about to complete.

module tb_char_stream_cipher;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic [7:0] pk_in;
  logic       pk_ready;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_char;
  logic       out_last;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       err_invalid_char;
  logic       err_overlength;
  logic       err_mode;

  char_stream_cipher dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .pk_in(pk_in),
    .pk_ready(pk_ready), .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
    .out_valid(out_valid), .out_char(out_char), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done), .err_invalid_char(err_invalid_char),
    .err_overlength(err_overlength), .err_mode(err_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ch;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   cur_dec;
  int   cur_key;
  int   msg_cnt;

  function automatic logic [7:0] model(bit dec, int k, int c);
    if (c == 0 || c >= 227) return 8'h00;
    if (dec) return 8'((c - k + 227) % 227);
    return 8'((c + k) % 227);
  endfunction

  // Inputs settle at posedge+1, so a handshake seen here completes on the next posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got char=%h last=%b, scoreboard empty", out_char, out_last);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_char !== e.ch || out_last !== e.last) begin
          bad++;
          $display("FAIL out_data: got char=%h last=%b, want char=%h last=%b",
                   out_char, out_last, e.ch, e.last);
        end
      end
    end
  end

  task automatic start_msg(input logic [1:0] m, input logic [7:0] k);
    @(posedge clk); #1 start = 1'b1; mode = m;
    @(posedge clk); #1 start = 1'b0; mode = 2'b11; pk_in = k; pk_ready = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL wait_key: busy=%b in_ready=%b, want busy=1 in_ready=0", busy, in_ready);
    end
    @(posedge clk); #1 pk_ready = 1'b0; pk_in = 8'hFF;
    cur_dec = m[0];
    cur_key = k;
    msg_cnt = 0;
  endtask

  task automatic send_char(input logic [7:0] c);
    bit ok = 0;
    exp_t e;
    in_valid = 1'b1;
    in_char  = c;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: char=%h never accepted", c);
    end else begin
      msg_cnt++;
      e.ch   = model(cur_dec, cur_key, c);
      e.last = (c == 8'h00) || (msg_cnt == 32);
      sb.push_back(e);
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout: done=0, want a pulse");
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL done_after: done=%b busy=%b pending=%0d, want 0 0 0", done, busy, sb.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, out_char, out_last, busy, done, err_invalid_char, err_overlength,
         err_mode, in_ready} !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b char=%h last=%b busy=%b done=%b errs=%b%b%b rdy=%b, want all 0",
               out_valid, out_char, out_last, busy, done, err_invalid_char, err_overlength,
               err_mode, in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    start_msg(2'b00, 8'd8);
    send_char(8'h41);
    send_char(8'h00);
    wait_done();
  endtask

  task automatic test_wrap();
    start_msg(2'b00, 8'd8);
    send_char(8'hE0);
    send_char(8'h00);
    wait_done();
    start_msg(2'b01, 8'd8);
    send_char(8'h05);
    send_char(8'h49);
    send_char(8'h00);
    wait_done();
    start_msg(2'b00, 8'd0);
    send_char(8'h7A);
    send_char(8'hE2);
    send_char(8'h00);
    wait_done();
  endtask

  task automatic test_invalid();
    start_msg(2'b00, 8'd8);
    send_char(8'h41);
    send_char(8'hE3);
    send_char(8'h42);
    send_char(8'h00);
    wait_done();
    total++;
    if (err_invalid_char !== 1'b1) begin
      bad++;
      $display("FAIL invalid_sticky: err_invalid_char=%b, want 1", err_invalid_char);
    end
    start_msg(2'b01, 8'd8);
    total++;
    if (err_invalid_char !== 1'b0) begin
      bad++;
      $display("FAIL invalid_clear: err_invalid_char=%b, want 0", err_invalid_char);
    end
    send_char(8'h00);
    wait_done();
  endtask

  task automatic test_back_to_back();
    start_msg(2'b01, 8'd100);
    fork
      begin
        for (int i = 0; i < 12; i++) send_char(8'($urandom_range(1, 226)));
        send_char(8'h00);
      end
      begin
        logic [7:0] held;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        held = out_char;
        for (int i = 0; i < 5; i++) begin
          total++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_char !== held) begin
            bad++;
            $display("FAIL stall_hold: valid=%b in_ready=%b char=%h, want 1 0 %h",
                     out_valid, in_ready, out_char, held);
          end
          @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_done();
  endtask

  task automatic test_overlength();
    start_msg(2'b00, 8'd3);
    for (int i = 0; i < 32; i++) send_char(8'($urandom_range(1, 226)));
    wait_done();
    total++;
    if (err_overlength !== 1'b1 || err_invalid_char !== 1'b0) begin
      bad++;
      $display("FAIL overlength: err_overlength=%b err_invalid=%b, want 1 0",
               err_overlength, err_invalid_char);
    end
  endtask

  task automatic test_mode_err();
    in_valid = 1'b1;
    in_char  = 8'h41;
    @(posedge clk); #1 start = 1'b1; mode = 2'b10;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    total++;
    if (err_mode !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mode_pulse: err_mode=%b busy=%b in_ready=%b, want 1 0 0", err_mode, busy, in_ready);
    end
    @(negedge clk);
    total++;
    if (err_mode !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mode_after: err_mode=%b busy=%b, want 0 0", err_mode, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    start_msg(2'b00, 8'd8);
    out_ready = 1'b0;
    send_char(8'h10);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_char, out_last, busy, done, err_invalid_char, err_overlength,
         err_mode, in_ready} !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid: valid=%b char=%h last=%b busy=%b done=%b rdy=%b, want all 0",
               out_valid, out_char, out_last, busy, done, in_ready);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    start_msg(2'b00, 8'd8);
    send_char(8'h00);
    wait_done();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; pk_in = 8'h00; pk_ready = 1'b0;
    in_valid = 1'b0; in_char = 8'h00; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_invalid();
    test_back_to_back();
    test_overlength();
    test_mode_err();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
